// File: rtl/mimi_mem_responder.sv
// Memory responder for minimax: arbitrates data and fetch ports onto
// four single-port SRAM banks, with a one-word fetch buffer.
module mimi_mem_responder #(
    parameter int PC_BITS         = 10,
    parameter int BANK_WORDS_LOG2 = 9
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PC_BITS-1:0]         inst_addr,
    output logic [15:0]                inst,
    output logic                       inst_valid,
    output logic                       fetch_stall,
    input  logic [31:0]                addr,
    input  logic [31:0]                wdata,
    input  logic [3:0]                 wmask,
    input  logic                       rreq,
    output logic [31:0]                rdata,
    output logic                       rvalid,
    output logic                       wack,
    output logic                       err,
    output logic [3:0]                 sram_csb,
    output logic                       sram_web,
    output logic [3:0]                 sram_wmask,
    output logic [BANK_WORDS_LOG2-1:0] sram_addr,
    output logic [31:0]                sram_din,
    input  logic [127:0]               sram_dout
);

    logic [12:0] fa;
    logic        wr_req;
    logic        rd_req;
    logic        data_req;
    logic        oor;
    logic [1:0]  d_bank;
    logic [1:0]  f_bank;
    logic [10:0] f_tag;
    logic        fill;
    logic        cur_valid;
    logic [10:0] cur_tag;
    logic        hit;
    logic        fetch_go;
    logic [31:0] fill_word;
    logic [31:0] fetch_word;
    logic        unused;

    // response / pending state
    logic        rv_q;
    logic        roor_q;
    logic [1:0]  r_bank;
    logic        wack_q;
    logic        err_q;
    logic        iv_q;
    logic        hit_q;
    logic        half_q;
    logic [1:0]  fill_bank;
    logic [10:0] fill_tag;
    logic [15:0] inst_q;
    logic [31:0] buf_data;
    logic [10:0] buf_tag;
    logic        buf_valid;

    assign fa       = 13'(inst_addr);
    assign wr_req   = |wmask;
    assign rd_req   = rreq & ~wr_req;
    assign data_req = wr_req | rreq;
    assign oor      = |addr[31:13];
    assign d_bank   = addr[12:11];
    assign f_bank   = fa[12:11];
    assign f_tag    = fa[12:2];
    assign unused   = ^{addr[1:0], fa[0]};

    // A fill landing this cycle counts as buffer content already, so a
    // fetch of the same word right behind a miss is a hit.
    assign fill      = iv_q & ~hit_q;
    assign cur_valid = buf_valid | fill;
    assign cur_tag   = fill ? fill_tag : buf_tag;
    assign hit       = cur_valid & (cur_tag == f_tag);
    assign fetch_go  = ~data_req;

    assign fill_word  = sram_dout[{fill_bank, 5'd0} +: 32];
    assign fetch_word = hit_q ? buf_data : fill_word;

    assign fetch_stall = rst_n & data_req;
    assign inst_valid  = iv_q;
    assign rvalid      = rv_q;
    assign wack        = wack_q;
    assign err         = err_q;
    assign sram_din    = wdata;

    // Response data: fetch halfword, or held value after a stalled fetch.
    always_comb begin
        inst  = inst_q;
        rdata = 32'd0;
        if (iv_q) begin
            inst = half_q ? fetch_word[31:16] : fetch_word[15:0];
        end
        if (rv_q && !roor_q) begin
            rdata = sram_dout[{r_bank, 5'd0} +: 32];
        end
    end

    // SRAM port control: write, then read, then fetch miss.
    always_comb begin
        sram_csb   = 4'hF;
        sram_web   = 1'b1;
        sram_wmask = 4'h0;
        sram_addr  = '0;
        if (rst_n) begin
            if (data_req && !oor) begin
                sram_csb[d_bank] = 1'b0;
                sram_web         = ~wr_req;
                sram_wmask       = wmask;
                sram_addr        = addr[2 +: BANK_WORDS_LOG2];
            end else if (fetch_go && !hit) begin
                sram_csb[f_bank] = 1'b0;
                sram_addr        = fa[2 +: BANK_WORDS_LOG2];
            end
        end
    end

    // Register responses, fill the fetch buffer, invalidate on writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rv_q      <= 1'b0;
            roor_q    <= 1'b0;
            r_bank    <= 2'd0;
            wack_q    <= 1'b0;
            err_q     <= 1'b0;
            iv_q      <= 1'b0;
            hit_q     <= 1'b0;
            half_q    <= 1'b0;
            fill_bank <= 2'd0;
            fill_tag  <= 11'd0;
            inst_q    <= 16'd0;
            buf_data  <= 32'd0;
            buf_tag   <= 11'd0;
            buf_valid <= 1'b0;
        end else begin
            rv_q      <= rd_req;
            roor_q    <= oor;
            r_bank    <= d_bank;
            wack_q    <= wr_req;
            err_q     <= data_req & (oor | (rreq & wr_req));
            iv_q      <= fetch_go;
            hit_q     <= hit;
            half_q    <= fa[1];
            fill_bank <= f_bank;
            fill_tag  <= f_tag;
            if (iv_q) begin
                inst_q <= inst;
            end
            if (fill) begin
                buf_data  <= fill_word;
                buf_tag   <= fill_tag;
                buf_valid <= 1'b1;
            end
            if (wr_req && !oor && addr[12:2] == cur_tag) begin
                buf_valid <= 1'b0;
            end
        end
    end

endmodule
